// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: branch resolve, redirect/flush sequencing and BPU update FIFO (BRANCH_STAT_EN adds counters)
module branch_redirect_ctrl #(
  parameter int UPD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  br_valid,
  input  logic [63:0] br_pc,
  input  logic [63:0] br_target,
  input  logic [1:0]  br_taken,
  input  logic [1:0]  br_pred_taken,
  input  logic [63:0] br_pred_target,
  input  logic        excp_flush_valid,
  input  logic [31:0] excp_target,
  output logic        ex_stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic        upd_mispred,
  input  logic        upd_ready
`ifdef BRANCH_STAT_EN
  ,
  output logic [31:0] stat_br_cnt,
  output logic [31:0] stat_mp_cnt
`endif
);
  localparam int AW = $clog2(UPD_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, REDIR} state_t;
  state_t state, state_nx;
  logic [1:0] mp, push_mask, push;
  logic [31:0] fix_pc [2];
  logic [65:0] ent [2];
  logic [65:0] q [UPD_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] count, free, n_push, n_acc;
  logic take, pop, br_redir;
  logic [31:0] br_redir_pc;
  for (genvar i = 0; i < 2; i++) begin : g_lane
    assign mp[i] = (br_taken[i] != br_pred_taken[i]) |
                   (br_taken[i] & (br_target[32*i+:32] != br_pred_target[32*i+:32]));
    assign fix_pc[i] = br_taken[i] ? br_target[32*i+:32] : br_pc[32*i+:32] + 32'd4;
    assign ent[i] = {br_pc[32*i+:32], br_target[32*i+:32], br_taken[i], mp[i]};
  end
  assign push_mask = {br_valid[1] & ~(br_valid[0] & mp[0]), br_valid[0]};
  assign n_push = CW'(push_mask[0]) + CW'(push_mask[1]);
  assign free = CW'(UPD_DEPTH) - count;
  assign ex_stall = (state == REDIR) | (free < n_push);
  assign take = (state == IDLE) & ~excp_flush_valid & ~ex_stall;
  assign push = take ? push_mask : 2'b00;
  assign n_acc = CW'(push[0]) + CW'(push[1]);
  assign br_redir = |(push & mp);
  assign br_redir_pc = (push[0] & mp[0]) ? fix_pc[0] : fix_pc[1];
  assign upd_valid = count != '0;
  assign pop = upd_valid & upd_ready;
  assign {upd_pc, upd_target, upd_taken, upd_mispred} = upd_valid ? q[rd] : '0;
  assign redirect_valid = state == REDIR;
  always_comb begin
    state_nx = (excp_flush_valid | br_redir) ? REDIR : redirect_ready ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      flush <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state <= state_nx;
      flush <= excp_flush_valid | br_redir;
      if (excp_flush_valid | br_redir)
        redirect_pc <= excp_flush_valid ? excp_target : br_redir_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= rd + AW'(pop);
      wr <= wr + AW'(n_acc);
      count <= count + n_acc - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (|push)
      q[wr] <= push[0] ? ent[0] : ent[1];
    if (&push)
      q[wr + AW'(1)] <= ent[1];
  end
`ifdef BRANCH_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_cnt <= '0;
      stat_mp_cnt <= '0;
    end else begin
      stat_br_cnt <= stat_br_cnt + 32'(n_acc);
      stat_mp_cnt <= stat_mp_cnt + 32'(br_redir);
    end
  end
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed stimulus checked against a queue-based behavioural model
module tb_branch_redirect_ctrl;
  localparam int DEPTH = 4;
  logic clk, rst;
  logic [1:0] br_valid, br_taken, br_pred_taken;
  logic [63:0] br_pc, br_target, br_pred_target;
  logic excp_flush_valid, redirect_ready, upd_ready;
  logic [31:0] excp_target;
  logic ex_stall, flush, redirect_valid, upd_valid, upd_taken, upd_mispred;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  branch_redirect_ctrl #(.UPD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_pc(br_pc), .br_target(br_target),
    .br_taken(br_taken), .br_pred_taken(br_pred_taken), .br_pred_target(br_pred_target),
    .excp_flush_valid(excp_flush_valid), .excp_target(excp_target), .ex_stall(ex_stall),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
    .upd_ready(upd_ready)
  );
  typedef struct packed {logic [31:0] pc, tgt; logic tk, mp;} ent_t;
  ent_t mq[$];
  bit m_redir = 0, m_flush = 0, chk_en = 0;
  logic [31:0] m_rpc = 0;
  int checks = 0, errors = 0;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit wrong(input int l);
    return (br_taken[l] != br_pred_taken[l]) ||
           (br_taken[l] && br_target[32*l+:32] != br_pred_target[32*l+:32]);
  endfunction
  function automatic logic [31:0] good_pc(input int l);
    return br_taken[l] ? br_target[32*l+:32] : br_pc[32*l+:32] + 32'd4;
  endfunction
  always @(negedge clk) begin
    int lanes[2];
    int n;
    bit stall, hit;
    n = 0;
    if (br_valid[0]) begin lanes[n] = 0; n++; end
    if (br_valid[1] && !(br_valid[0] && wrong(0))) begin lanes[n] = 1; n++; end
    stall = m_redir || (DEPTH - mq.size()) < n;
    if (chk_en) begin
      chk("ex_stall", 32'(ex_stall), 32'(stall));
      chk("flush", 32'(flush), 32'(m_flush));
      chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
      if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
      chk("upd_valid", 32'(upd_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("upd_pc", upd_pc, mq[0].pc);
        chk("upd_target", upd_target, mq[0].tgt);
        chk("upd_taken", 32'(upd_taken), 32'(mq[0].tk));
        chk("upd_mispred", 32'(upd_mispred), 32'(mq[0].mp));
      end
    end
    if (rst) begin
      mq.delete();
      m_redir = 0;
      m_flush = 0;
      m_rpc = 0;
    end else begin
      if (mq.size() > 0 && upd_ready) void'(mq.pop_front());
      m_flush = 0;
      if (excp_flush_valid) begin
        m_flush = 1;
        m_redir = 1;
        m_rpc = excp_target;
      end else if (m_redir) begin
        if (redirect_ready) m_redir = 0;
      end else if (!stall) begin
        hit = 0;
        for (int k = 0; k < n; k++) begin
          mq.push_back('{br_pc[32*lanes[k]+:32], br_target[32*lanes[k]+:32],
                         br_taken[lanes[k]], wrong(lanes[k])});
          if (!hit && wrong(lanes[k])) begin
            hit = 1;
            m_flush = 1;
            m_redir = 1;
            m_rpc = good_pc(lanes[k]);
          end
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic lane(input int l, input logic [31:0] pc, tgt, input logic tk, ptk,
                      input logic [31:0] ptgt);
    br_pc[32*l+:32] = pc;
    br_target[32*l+:32] = tgt;
    br_taken[l] = tk;
    br_pred_taken[l] = ptk;
    br_pred_target[32*l+:32] = ptgt;
  endtask
  initial begin
    rst = 1; br_valid = 0; br_pc = 0; br_target = 0; br_taken = 0; br_pred_taken = 0;
    br_pred_target = 0; excp_flush_valid = 0; excp_target = 0; redirect_ready = 0; upd_ready = 1;
    tick; tick;
    rst = 0; chk_en = 1;
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_rv", 32'(redirect_valid), 32'd0);
    chk("rst_uv", 32'(upd_valid), 32'd0);
    #1 chk("rst_stall", 32'(ex_stall), 32'd0);
    lane(0, 32'h1C000000, 32'h1C000100, 1, 1, 32'h1C000100);
    br_valid = 2'b01;
    tick; br_valid = 0;
    chk("t1_flush", 32'(flush), 32'd0);
    chk("t1_uv", 32'(upd_valid), 32'd1);
    chk("t1_upc", upd_pc, 32'h1C000000);
    chk("t1_utk", 32'(upd_taken), 32'd1);
    chk("t1_ump", 32'(upd_mispred), 32'd0);
    tick;
    lane(0, 32'h1C000010, 32'h1C000020, 0, 1, 32'h1C000020);
    lane(1, 32'h1C000014, 32'h1C000040, 1, 1, 32'h1C000040);
    br_valid = 2'b11;
    tick; br_valid = 0;
    chk("t2_flush", 32'(flush), 32'd1);
    chk("t2_rpc", redirect_pc, 32'h1C000014);
    chk("t2_upc", upd_pc, 32'h1C000010);
    chk("t2_ump", 32'(upd_mispred), 32'd1);
    lane(0, 32'h1C000500, 32'h1C000600, 1, 0, 32'h0);
    br_valid = 2'b01;
    #1 chk("t3_stall", 32'(ex_stall), 32'd1);
    tick;
    chk("t3_flush0", 32'(flush), 32'd0);
    chk("t3_rv1", 32'(redirect_valid), 32'd1);
    chk("t3_uv0", 32'(upd_valid), 32'd0);
    tick; tick;
    chk("t3_rpc_hold", redirect_pc, 32'h1C000014);
    br_valid = 0; redirect_ready = 1;
    tick; redirect_ready = 0;
    chk("t3_rv0", 32'(redirect_valid), 32'd0);
    #1 chk("t3_stall0", 32'(ex_stall), 32'd0);
    lane(0, 32'h1C000200, 32'h1C000300, 1, 0, 32'h1C000300);
    br_valid = 2'b01;
    tick; br_valid = 0;
    chk("t4_rpc", redirect_pc, 32'h1C000300);
    excp_flush_valid = 1; excp_target = 32'h1C008000; redirect_ready = 1;
    tick; excp_flush_valid = 0; redirect_ready = 0;
    chk("t4_reflush", 32'(flush), 32'd1);
    chk("t4_rv", 32'(redirect_valid), 32'd1);
    chk("t4_rpc_ex", redirect_pc, 32'h1C008000);
    tick;
    chk("t4_flush0", 32'(flush), 32'd0);
    redirect_ready = 1;
    tick; redirect_ready = 0;
    chk("t4_rv0", 32'(redirect_valid), 32'd0);
    upd_ready = 0;
    lane(0, 32'h1C001000, 32'h1C001100, 1, 1, 32'h1C001100);
    lane(1, 32'h1C001004, 32'h1C001200, 0, 0, 32'h1C001200);
    br_valid = 2'b11;
    tick;
    lane(0, 32'h1C001010, 32'h1C001080, 1, 1, 32'h1C001080);
    br_valid = 2'b01;
    tick;
    lane(0, 32'h1C001020, 32'h1C0010A0, 1, 1, 32'h1C0010A0);
    lane(1, 32'h1C001024, 32'h1C0010C0, 1, 1, 32'h1C0010C0);
    br_valid = 2'b11;
    #1 chk("t5_stall", 32'(ex_stall), 32'd1);
    tick;
    chk("t5_stall_hold", 32'(ex_stall), 32'd1);
    chk("t5_head", upd_pc, 32'h1C001000);
    upd_ready = 1;
    tick; upd_ready = 0;
    #1 chk("t5_unstall", 32'(ex_stall), 32'd0);
    chk("t5_head2", upd_pc, 32'h1C001004);
    tick; br_valid = 0;
    br_valid = 2'b01;
    #1 chk("t5_full", 32'(ex_stall), 32'd1);
    br_valid = 0; upd_ready = 1;
    tick;
    chk("t5_head3", upd_pc, 32'h1C001010);
    repeat (4) tick;
    chk("t5_empty", 32'(upd_valid), 32'd0);
    lane(0, 32'hFFFFFFFC, 32'h00001000, 0, 1, 32'h00001000);
    br_valid = 2'b01;
    tick; br_valid = 0;
    chk("t6_rpc_wrap", redirect_pc, 32'h00000000);
    chk("t6_flush", 32'(flush), 32'd1);
    redirect_ready = 1;
    tick; redirect_ready = 0;
    lane(0, 32'h1C002000, 32'h1C002100, 0, 0, 32'h0);
    lane(1, 32'h1C002004, 32'h1C002300, 1, 1, 32'h1C002200);
    br_valid = 2'b11;
    tick; br_valid = 0;
    chk("t7_rpc_l1", redirect_pc, 32'h1C002300);
    chk("t7_head", upd_pc, 32'h1C002000);
    redirect_ready = 1;
    tick; redirect_ready = 0;
    repeat (2) tick;
    lane(0, 32'h1C003000, 32'h1C003100, 1, 0, 32'h0);
    br_valid = 2'b01; excp_flush_valid = 1; excp_target = 32'h1C00A000;
    tick; br_valid = 0; excp_flush_valid = 0;
    chk("t8_rpc_ex", redirect_pc, 32'h1C00A000);
    chk("t8_nopush", 32'(upd_valid), 32'd0);
    rst = 1;
    tick; rst = 0;
    chk("t9_rv0", 32'(redirect_valid), 32'd0);
    chk("t9_flush0", 32'(flush), 32'd0);
    repeat (3) tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Resolves branch outcomes from the two execute lanes (BEQ/BNE/BLT/BGE/BLTU/BGEU/B/BL/JIRL, `ALU_SEL_JUMP_BRANCH`).
- Detects mispredicts and picks the oldest redirect, with exception flushes from commit taking priority.
- Sequences the pipeline flush and the fetch redirect handshake.
- Queues predictor-update records for the BPU in a small FIFO.

Parameters:
- UPD_DEPTH, 4, update FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- br_valid  in  2  per-lane resolved branch valid; lane0 is older
- br_pc  in  64  lane-packed branch PC, lane0 = [31:0]
- br_target  in  64  lane-packed actual target
- br_taken  in  2  actual direction
- br_pred_taken  in  2  predicted direction
- br_pred_target  in  64  predicted target
- excp_flush_valid  in  1  commit exception/ertn flush request
- excp_target  in  32  exception/ertn redirect PC
- ex_stall  out  1  execute must hold its branch inputs this cycle
- flush  out  1  one-cycle pipeline flush pulse
- redirect_valid  out  1  fetch redirect pending
- redirect_pc  out  32  redirect PC
- redirect_ready  in  1  fetch accepts redirect
- upd_valid  out  1  BPU update available
- upd_pc  out  32  update PC
- upd_target  out  32  update actual target
- upd_taken  out  1  update direction
- upd_mispred  out  1  update was mispredicted
- upd_ready  in  1  BPU accepts update

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - FIFO empty, with read/write pointers and count 0.
- Mispredict rule, per lane: mp = (taken != pred_taken) | (taken & (target != pred_target)).
- Fall-through PC = pc + 32'd4, mod 2^32 (0xFFFFFFFC wraps to 0).
- Correct PC for a lane = taken ? target : pc+4.
- Lane ordering:
  - If lane0 is valid and mp, lane1 is squashed.
  - A squashed lane1 causes no redirect and no FIFO push.
- Push set:
  - The lanes that are valid and not squashed, taken in order lane0 then lane1.
  - Up to 2 pushes per cycle.
- ex_stall is combinational: 1 when state==REDIR, or when free FIFO entries < number of lanes to push.
  - While ex_stall=1 in IDLE, inputs are not consumed: no push and no mispredict action.
  - Upstream holds its inputs stable.
- State IDLE:
  - If excp_flush_valid: next cycle flush=1, redirect_valid=1, redirect_pc=excp_target, go to REDIR. Branch inputs are ignored that cycle (no push).
  - Else, if not stalled and a pushed lane mispredicts (first in order): next cycle flush=1, redirect_valid=1, redirect_pc = that lane's correct PC, go to REDIR.
  - Else no action.
- State REDIR:
  - redirect_valid and redirect_pc are held stable.
  - flush is 0 except for a re-flush.
  - Branch inputs are ignored (wrong path). ex_stall=1.
  - If excp_flush_valid: next cycle flush=1, redirect_pc=excp_target, stay in REDIR. This wins over a simultaneous redirect_ready.
  - Else, if redirect_ready: next cycle redirect_valid=0, go to IDLE.
- Latency:
  - flush and redirect appear exactly 1 cycle after detection.
  - The earliest next redirect after acceptance is 1 cycle later.
- Update FIFO:
  - First-word-fall-through: upd_* reflect the head entry when count>0.
  - Pop on upd_valid & upd_ready.
  - Push and pop in the same cycle are legal when full.
  - Pointers wrap modulo UPD_DEPTH.
  - excp_flush_valid does not clear the FIFO; entries are resolved, architecturally older branches.
- rst mid-operation returns to the reset state in the next cycle and drops any pending redirect.

Optional Feature:
- BRANCH_STAT_EN defined:
  - Adds outputs stat_br_cnt[31:0] and stat_mp_cnt[31:0].
  - stat_br_cnt increments by the number of pushes per cycle (0–2).
  - stat_mp_cnt increments by 1 per branch-mispredict redirect (exceptions excluded).
  - Both counters wrap and reset to 0.
- BRANCH_STAT_EN undefined: the counter ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Lane0 BEQ at 0x1C000000, taken, target 0x1C000100, predicted taken to 0x1C000100 → no flush; one update {pc=0x1C000000, taken=1, mispred=0}.
- Lane0 BNE at 0x1C000010, not taken, predicted taken, with lane1 valid → next cycle flush=1, redirect_pc=0x1C000014; only lane0 pushed.
- Mispredict with redirect_ready=0 for 3 cycles → redirect_valid/pc stable for 4 cycles, ex_stall=1 throughout; IDLE the cycle after ready.
- In REDIR, excp_flush_valid with excp_target=0x1C008000 together with redirect_ready=1 → flush re-pulses, redirect_pc=0x1C008000, state stays REDIR.
- UPD_DEPTH=4, upd_ready=0, 3 entries queued, two valid lanes arrive → ex_stall=1, no push; after one pop both lanes push, count=4.
- JIRL at 0xFFFFFFFC, not taken, predicted taken → redirect_pc=0x00000000.
